// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty stage.
// Optional dead-time feature is selected in the top via PWM_DEADTIME_EN.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 7;
    localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

    // Pending duty buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/pwm_duty_stage_deadtime.sv
// Dead-time inserter: turns one raw PWM level into complementary outputs
// with a both-low gap of DEAD_CYCLES clocks after every raw edge.
module deadtime_inserter
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic raw,
    output logic pwm,
    output logic pwm_n
);

    logic [3:0] cnt;
    logic       lvl;
    logic       idle;

    // idle marks "no valid level yet" so the first level after enable or
    // reset also waits out a full dead-time gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 4'(DEAD_CYCLES);
            lvl   <= 1'b0;
            idle  <= 1'b1;
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else if (!en) begin
            idle  <= 1'b1;
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else if (idle || (raw != lvl)) begin
            idle  <= 1'b0;
            lvl   <= raw;
            cnt   <= 4'(DEAD_CYCLES);
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
        end else begin
            cnt   <= '0;
            pwm   <= lvl;
            pwm_n <= !lvl;
        end
    end

endmodule

// File: rtl/pwm_duty_stage.sv
// PWM compare stage fed by a down-counter, with a double-buffered duty value
// applied only at the 0 -> all-ones wrap. Define PWM_DEADTIME_EN for complementary outputs.
module pwm_duty_stage
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = PWM_WIDTH,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             pwm_out_n,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] MAX = '1;

    if ((DEAD_CYCLES < 1) || (DEAD_CYCLES > 15)) begin : g_dead_range
        $error("pwm_duty_stage: DEAD_CYCLES must be within 1..15");
    end

    buf_state_t       state, state_nx;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] pend_duty, pend_nx;
    logic [WIDTH-1:0] active_duty, active_nx;
    logic             wrap;
    logic             raw;
    logic             raw_g;

    // A reload that skips 0 never matches here, so only a true wrap counts.
    always_comb begin
        wrap = en && (count_d == '0) && (count == MAX);
    end

    always_comb begin
        state_nx  = state;
        pend_nx   = pend_duty;
        active_nx = active_duty;
        unique case (state)
            ST_EMPTY: begin
                if (duty_valid) begin
                    pend_nx  = duty_in;
                    state_nx = ST_FULL;
                end
            end
            ST_FULL: begin
                if (wrap) begin
                    active_nx = pend_duty;
                    state_nx  = ST_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_EMPTY;
            count_d      <= '1;
            pend_duty    <= '0;
            active_duty  <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nx;
            count_d      <= count;
            pend_duty    <= pend_nx;
            active_duty  <= active_nx;
            period_start <= wrap;
        end
    end

    always_comb begin
        duty_ready = (state == ST_EMPTY);
        raw        = (count < active_duty) || (active_duty == MAX);
        raw_g      = en && raw;
    end

`ifdef PWM_DEADTIME_EN
    deadtime_inserter #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_deadtime (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .raw   (raw_g),
        .pwm   (pwm_out),
        .pwm_n (pwm_out_n)
    );
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= raw_g;
        end
    end

    always_comb begin
        pwm_out_n = 1'b0;
    end
`endif

endmodule

// File: tb/tb_pwm_duty_stage.sv
// Self-checking bench for pwm_duty_stage: directed scenarios plus randomized
// traffic against a behavioural model (also models PWM_DEADTIME_EN when defined).
module tb_pwm_duty_stage;
    import pwm_pkg::*;

    localparam int unsigned W    = 7;
    localparam int          MAXV = 127;
    localparam int          DEAD = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] count;
    logic [W-1:0] duty_in;
    logic         duty_valid;
    logic         duty_ready;
    logic         pwm_out;
    logic         pwm_out_n;
    logic         period_start;

    always #5 clk = ~clk;

    pwm_duty_stage #(
        .WIDTH(W),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .count        (count),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .pwm_out_n    (pwm_out_n),
        .period_start (period_start)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: previous count, pending queue (depth 1), active duty,
    // and a history of the gated compare level (2 = stage disabled/reset).
    int m_prev_count;
    int pend_q[$];
    int m_active;
    bit m_pwm, m_pwm_n, m_ps;
    int hist[$];
    bit accepted_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_prev_count = MAXV;
        pend_q.delete();
        m_active = 0;
        m_pwm = 1'b0;
        m_pwm_n = 1'b0;
        m_ps = 1'b0;
        accepted_last = 1'b0;
        hist.delete();
        for (int i = 0; i < DEAD + 1; i++) hist.push_back(2);
    endfunction

    function automatic void model_step();
        bit boundary;
        bit lvl;
        int c;
        c = int'(count);
        boundary = en && (m_prev_count == 0) && (c == MAXV);
        lvl = en && ((c < m_active) || (m_active == MAXV));
        hist.push_back(en ? int'(lvl) : 2);
        void'(hist.pop_front());
        m_ps = boundary;
`ifdef PWM_DEADTIME_EN
        m_pwm = 1'b1;
        m_pwm_n = 1'b1;
        foreach (hist[i]) begin
            if (hist[i] != 1) m_pwm = 1'b0;
            if (hist[i] != 0) m_pwm_n = 1'b0;
        end
`else
        m_pwm = lvl;
        m_pwm_n = 1'b0;
`endif
        accepted_last = 1'b0;
        if (boundary && (pend_q.size() > 0)) begin
            m_active = pend_q.pop_front();
        end else if ((pend_q.size() == 0) && duty_valid) begin
            pend_q.push_back(int'(duty_in));
            accepted_last = 1'b1;
        end
        m_prev_count = c;
    endfunction

    task automatic compare();
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("pwm_out_n", 32'(pwm_out_n), 32'(m_pwm_n));
        check("duty_ready", 32'(duty_ready), 32'(pend_q.size() == 0));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("outputs_overlap", 32'(pwm_out && pwm_out_n), 32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            count = count - 1'b1;
        end
    endtask

    task automatic send_duty(input int d);
        duty_in = W'(d);
        duty_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            step();
            count = count - 1'b1;
            if (accepted_last) begin
                duty_valid = 1'b0;
                return;
            end
        end
        duty_valid = 1'b0;
        check("handshake_timeout", 32'(1), 32'(0));
    endtask

    task automatic wait_ps();
        for (int k = 0; k < 300; k++) begin
            step();
            count = count - 1'b1;
            if (m_ps) return;
        end
        check("wrap_timeout", 32'(1), 32'(0));
    endtask

    task automatic window(input string nm, input int exp_highs);
        int highs;
        int starts;
        highs = 0;
        starts = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            count = count - 1'b1;
            highs += int'(pwm_out);
            starts += int'(period_start);
        end
`ifndef PWM_DEADTIME_EN
        check(nm, 32'(highs), 32'(exp_highs));
`endif
        check({nm, "_starts"}, 32'(starts), 32'(1));
    endtask

    initial begin
        int highs;
        reset = 1'b1;
        en = 1'b0;
        count = W'(MAXV);
        duty_in = '0;
        duty_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'(0));
        check("rst_pwm_n", 32'(pwm_out_n), 32'(0));
        check("rst_ready", 32'(duty_ready), 32'(1));
        check("rst_ps", 32'(period_start), 32'(0));
        reset = 1'b0;
        en = 1'b1;

        // Duty 32 applied at the next wrap, 32 highs per 128-cycle period
        send_duty(32);
        check("t2_not_yet_active", 32'(m_active), 32'(0));
        wait_ps();
        check("t2_active", 32'(m_active), 32'(32));
        run(2);
        window("t2_highs", 32);

        // Duty 0 for one full period, then 127 (constant high)
        send_duty(0);
        send_duty(127);
        check("t4_active_zero", 32'(m_active), 32'(0));
        highs = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            count = count - 1'b1;
            highs += int'(pwm_out);
            if (m_ps) break;
        end
        check("t4_zero_highs", 32'(highs), 32'(0));
        check("t4_active_full", 32'(m_active), 32'(127));
        run(DEAD + 2);
        window("t4_full_highs", 128);

        // duty_valid exactly on the wrap cycle: taken into pending, applied next wrap
        for (int k = 0; k < 300; k++) begin
            if (count == W'(MAXV)) break;
            step();
            count = count - 1'b1;
        end
        duty_in = W'(10);
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        count = count - 1'b1;
        check("t3_ps", 32'(period_start), 32'(1));
        check("t3_ready", 32'(duty_ready), 32'(0));
        check("t3_active_held", 32'(m_active), 32'(127));
        wait_ps();
        check("t3_active", 32'(m_active), 32'(10));
        run(2);
        window("t3_highs", 10);

        // Second request while FULL is held off until ready returns
        send_duty(50);
        duty_in = W'(60);
        duty_valid = 1'b1;
        step();
        count = count - 1'b1;
        check("t5_ready_full", 32'(duty_ready), 32'(0));
        check("t5_pending_kept", 32'(pend_q[0]), 32'(50));
        send_duty(60);
        check("t5_taken_after_apply", 32'(m_active), 32'(50));
        wait_ps();
        check("t5_active", 32'(m_active), 32'(60));

        // Reset mid-period while FULL, asserted away from the clock edge
        send_duty(20);
        for (int k = 0; k < 200; k++) begin
            if ((count < W'(40)) && (count > W'(10))) break;
            step();
            count = count - 1'b1;
        end
        check("t1_pwm_high_before", 32'(pwm_out), 32'(1));
        @(posedge clk);
        model_step();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("t1_pwm", 32'(pwm_out), 32'(0));
        check("t1_ready", 32'(duty_ready), 32'(1));
        check("t1_ps", 32'(period_start), 32'(0));
        @(negedge clk);
        count = count - 1'b1;
        run(2);
        reset = 1'b0;
        wait_ps();
        check("t1_pending_discarded", 32'(m_active), 32'(0));

        // Randomized traffic: enable drops, reloads skipping 0, random handshakes
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 15) != 0);
            duty_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0: duty_in = '0;
                1: duty_in = '1;
                default: duty_in = W'($urandom_range(0, MAXV));
            endcase
            step();
            if ($urandom_range(0, 39) == 0) count = W'($urandom_range(1, MAXV));
            else count = count - 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
